// File: rtl/calc_pkg.sv
// Shared op codes, FSM state codes and default width for the calculator datapath and controller.
package calc_pkg;

    localparam int unsigned CALC_W = 8;

    typedef enum logic [2:0] {
        OpNop = 3'b000,
        OpAdd = 3'b001,
        OpSub = 3'b010,
        OpMul = 3'b011,
        OpXor = 3'b100,
        OpDiv = 3'b101,
        OpMod = 3'b110,
        OpAnd = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        StIdle = 3'b000,
        StExec = 3'b001,
        StMul  = 3'b010,
        StDiv  = 3'b011,
        StDone = 3'b100
    } state_e;

endpackage

// File: rtl/calc_alu_engine_if.sv
// Controller <-> ALU engine handshake: register-file writes, op request and result status.
interface calc_alu_engine_if
    import calc_pkg::*;
#(
    parameter int unsigned W = CALC_W
);
    logic           WE;
    logic           W1;
    logic [W-1:0]   Din;
    logic [2:0]     MS_in;
    logic           Start;
    logic           Ack;
    logic [2*W-1:0] Result;
    logic           Busy;
    logic           Valid;
    logic           DivZero;
    logic [2:0]     State;

    modport master (
        output WE, W1, Din, MS_in, Start, Ack,
        input  Result, Busy, Valid, DivZero, State
    );

    modport slave (
        input  WE, W1, Din, MS_in, Start, Ack,
        output Result, Busy, Valid, DivZero, State
    );
endinterface

// File: rtl/calc_iter_unit.sv
// W-cycle iterative engine: shift-add multiply or restoring divide sharing one accumulator.
module calc_iter_unit
    import calc_pkg::*;
#(
    parameter int unsigned W = CALC_W
) (
    input  logic           CLK,
    input  logic           RST_n,
    input  logic           start,
    input  logic           is_div,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] acc
);
    localparam int unsigned CW = $clog2(W + 1);

    logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           active_q, active_d, is_div_q, is_div_d;
    logic [W:0]     rem_sh, diff;

    // Divide mode: acc holds {remainder, dividend/quotient}; opb holds the divisor.
    // Multiply mode: acc is the product, mcand the shifted multiplicand, opb the multiplier.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        is_div_d = is_div_q;
        rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
        diff     = rem_sh - {1'b0, opb_q};
        if (start) begin
            acc_d    = is_div ? {{W{1'b0}}, a} : '0;
            mcand_d  = {{W{1'b0}}, a};
            opb_d    = b;
            cnt_d    = '0;
            active_d = 1'b1;
            is_div_d = is_div;
        end else if (active_q && cnt_q != CW'(W)) begin
            cnt_d = cnt_q + 1'b1;
            if (is_div_q) begin
                if (!diff[W]) acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
                else          acc_d = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
            end else begin
                if (opb_q[0]) acc_d = acc_q + mcand_q;
                mcand_d = mcand_q << 1;
                opb_d   = opb_q >> 1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            is_div_q <= is_div_d;
        end
    end

    assign done = active_q && (cnt_q == CW'(W));
    assign acc  = acc_q;
endmodule

// File: rtl/calc_alu_engine.sv
// Calculator datapath: operand register file, op FSM, single-cycle ALU and result register.
module calc_alu_engine
    import calc_pkg::*;
#(
    parameter int unsigned W = CALC_W
) (
    input logic               CLK,
    input logic               RST_n,
    calc_alu_engine_if.slave  bus
);
    logic [W-1:0]   rf_a_q, rf_b_q, a_q, b_q;
    op_e            op_q, ms_op;
    state_e         state_q, state_d;
    logic [2*W-1:0] result_q, result_d, alu_res, iter_acc;
    logic           divzero_q, divzero_d;
    logic           busy, accept, iter_start, iter_done, is_divmod_in, b_zero_in;

    assign ms_op        = op_e'(bus.MS_in);
    assign busy         = (state_q == StExec) || (state_q == StMul) || (state_q == StDiv);
    assign accept       = bus.Start && !busy && (ms_op != OpNop);
    assign is_divmod_in = (ms_op == OpDiv) || (ms_op == OpMod);
    assign b_zero_in    = (rf_b_q == '0);
    assign iter_start   = accept && ((ms_op == OpMul) || (is_divmod_in && !b_zero_in));

    calc_iter_unit #(.W(W)) u_iter (
        .CLK    (CLK),
        .RST_n  (RST_n),
        .start  (iter_start),
        .is_div (ms_op != OpMul),
        .a      (rf_a_q),
        .b      (rf_b_q),
        .done   (iter_done),
        .acc    (iter_acc)
    );

    // Ops finishing from EXEC, including div/mod by zero.
    always_comb begin
        alu_res = '0;
        case (op_q)
            OpAdd:   alu_res = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
            OpSub:   alu_res = {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
            OpXor:   alu_res = {{W{1'b0}}, a_q ^ b_q};
            OpAnd:   alu_res = {{W{1'b0}}, a_q & b_q};
            OpDiv:   alu_res = {{W{1'b0}}, {W{1'b1}}};
            OpMod:   alu_res = {{W{1'b0}}, a_q};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        divzero_d = divzero_q;
        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    divzero_d = 1'b0;
                    if (ms_op == OpMul)                  state_d = StMul;
                    else if (is_divmod_in && !b_zero_in) state_d = StDiv;
                    else                                 state_d = StExec;
                end else if (state_q == StDone && bus.Ack) begin
                    state_d = StIdle;
                end
            end
            StExec: begin
                state_d   = StDone;
                result_d  = alu_res;
                divzero_d = (op_q == OpDiv) || (op_q == OpMod);
            end
            StMul: begin
                if (iter_done) begin
                    state_d  = StDone;
                    result_d = iter_acc;
                end
            end
            StDiv: begin
                if (iter_done) begin
                    state_d  = StDone;
                    result_d = (op_q == OpDiv) ? {{W{1'b0}}, iter_acc[W-1:0]}
                                               : {{W{1'b0}}, iter_acc[2*W-1:W]};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rf_a_q    <= '0;
            rf_b_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OpNop;
            state_q   <= StIdle;
            result_q  <= '0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            divzero_q <= divzero_d;
            if (bus.WE && !busy) begin
                if (bus.W1) rf_b_q <= bus.Din;
                else        rf_a_q <= bus.Din;
            end
            if (accept) begin
                op_q <= ms_op;
                a_q  <= rf_a_q;
                b_q  <= rf_b_q;
            end
        end
    end

    assign bus.Result  = result_q;
    assign bus.Busy    = busy;
    assign bus.Valid   = (state_q == StDone);
    assign bus.DivZero = divzero_q;
    assign bus.State   = state_q;
endmodule
